divider_seq: RTL and testbench

Sequential 32-bit integer divider for the RISC5 core; the counterpart of the single-cycle multiplier on the CPU's arithmetic path. It executes DIV (quotient) and returns the remainder for MOD. It uses the same run/stall handshake as the multiplier, so the CPU pipeline freezes until the result is ready. Radix-2 restoring algorithm, one quotient bit per clock, with sign pre- and post-correction for Euclidean signed division.

---
 rtl/divider_seq.sv | 151 +++++++++++++++
 tb/tb_divider_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Sequential 32-bit radix-2 restoring divider with Euclidean signed correction.
// Uses the run/stall handshake: stall stays high until the single DONE cycle.
module divider_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        u,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] x_abs;
    logic [31:0] y_abs;
    logic [31:0] y_mag;
    logic [31:0] q_reg;
    logic [31:0] r_reg;
    logic        sx;
    logic        sy;
    logic [4:0]  cnt;

    logic [32:0] shifted;
    logic        no_borrow;
    logic [31:0] diff;
    logic [31:0] q_plus;
    logic [31:0] fix_quot;
    logic [31:0] fix_rem;

    // Magnitudes of the incoming operands; only negated in signed mode.
    always_comb begin
        x_abs = (x[31] & ~u) ? (32'd0 - x) : x;
        y_abs = (y[31] & ~u) ? (32'd0 - y) : y;
    end

    // The difference fits in 32 bits whenever no borrow occurs, because the
    // previous partial remainder was already below the divisor magnitude.
    always_comb begin
        shifted   = {r_reg, q_reg[31]};
        no_borrow = (shifted >= {1'b0, y_mag});
        diff      = shifted[31:0] - y_mag;
    end

    always_comb begin
        q_plus   = q_reg + 32'd1;
        fix_quot = q_reg;
        fix_rem  = r_reg;
        if (!sx) begin
            fix_quot = sy ? (32'd0 - q_reg) : q_reg;
            fix_rem  = r_reg;
        end else if (r_reg == 32'd0) begin
            fix_quot = sy ? q_reg : (32'd0 - q_reg);
            fix_rem  = 32'd0;
        end else begin
            fix_quot = sy ? q_plus : (32'd0 - q_plus);
            fix_rem  = y_mag - r_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (cnt == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = run ? DONE : IDLE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign stall = run & (state != DONE);

    // The quotient register starts out holding |x| so its MSB feeds the
    // partial remainder while quotient bits fill in from the bottom.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_mag <= 32'd0;
            q_reg <= 32'd0;
            r_reg <= 32'd0;
            sx    <= 1'b0;
            sy    <= 1'b0;
            cnt   <= 5'd0;
            quot  <= 32'd0;
            rem   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        y_mag <= y_abs;
                        q_reg <= x_abs;
                        r_reg <= 32'd0;
                        sx    <= x[31] & ~u;
                        sy    <= y[31] & ~u;
                        cnt   <= 5'd0;
                    end
                end
                BUSY: begin
                    if (run) begin
                        r_reg <= no_borrow ? diff : shifted[31:0];
                        q_reg <= {q_reg[30:0], no_borrow};
                        cnt   <= cnt + 5'd1;
                    end
                end
                FIX: begin
                    if (run) begin
                        quot <= fix_quot;
                        rem  <= fix_rem;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: stimulus pushes expected results, a
// negedge monitor pops and compares them whenever the DONE cycle appears.
module tb_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        u;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [31:0] quot;
    logic [31:0] rem;

    int          n_checks = 0;
    int          n_fail = 0;
    int          stall_cnt = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    divider_seq dut (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .u    (u),
        .x    (x),
        .y    (y),
        .stall(stall),
        .quot (quot),
        .rem  (rem)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Euclidean reference built on 64-bit truncating division.
    function automatic logic [63:0] ref_div(input logic uu, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (uu) begin
            if (b == 32'd0) return {32'hFFFFFFFF, a};
            return {a / b, a % b};
        end
        if (b == 32'd0) return a[31] ? {32'h0, a} : {32'hFFFFFFFF, a};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        if (r < 0) begin
            if (sb > 0) begin
                q = q - 1;
                r = r + sb;
            end else begin
                q = q + 1;
                r = r - sb;
            end
        end
        return {q[31:0], r[31:0]};
    endfunction

    always @(negedge clk) begin
        if (rst !== 1'b1 || run !== 1'b1) begin
            stall_cnt = 0;
        end else if (stall) begin
            stall_cnt++;
        end else begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_result: got quot=0x%08h rem=0x%08h, expected none", quot, rem);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check_output("quot", quot, e[63:32]);
                check_output("rem", rem, e[31:0]);
                check_output("stall_cycles", 32'(stall_cnt), 32'd34);
            end
            stall_cnt = 0;
        end
    end

    // Entered at posedge+1; returns at posedge+1 after DONE with run still high.
    task automatic apply_stimulus(input logic uu, input logic [31:0] a, input logic [31:0] b,
                                  input logic [63:0] expected);
        bit seen;
        exp_q.push_back(expected);
        u   = uu;
        x   = a;
        y   = b;
        run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (stall === 1'b0) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL timeout: got no DONE for x=0x%08h y=0x%08h, expected one within 80 cycles", a, b);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        run = 1'b1;
        u   = 1'b1;
        x   = 32'd0;
        y   = 32'd0;
        #12;
        check_output("reset_quot", quot, 32'd0);
        check_output("reset_rem", rem, 32'd0);
        check_output("reset_stall", {31'd0, stall}, 32'd1);
        run = 1'b0;
        #1;
        check_output("reset_stall_idle", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, back-to-back with run held through DONE.
        apply_stimulus(1'b1, 32'd100,        32'd7,          {32'd14,         32'd2});
        apply_stimulus(1'b0, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFC,   32'd1});
        apply_stimulus(1'b0, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'd4,          32'd1});
        apply_stimulus(1'b0, 32'd7,          32'hFFFFFFFE,   {32'hFFFFFFFD,   32'd1});
        apply_stimulus(1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000,   32'd0});
        apply_stimulus(1'b1, 32'hFFFFFFFF,   32'd1,          {32'hFFFFFFFF,   32'd0});
        apply_stimulus(1'b1, 32'h12345678,   32'd0,          {32'hFFFFFFFF,   32'h12345678});
        apply_stimulus(1'b0, 32'h12345678,   32'd0,          {32'hFFFFFFFF,   32'h12345678});
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Abort in cycle 10: results must hold.
        u   = 1'b1;
        x   = 32'd50;
        y   = 32'd3;
        run = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("abort_quot", quot, 32'hFFFFFFFF);
        check_output("abort_rem", rem, 32'h12345678);
        check_output("abort_stall", {31'd0, stall}, 32'd0);
        apply_stimulus(1'b1, 32'd1000, 32'd10, {32'd100, 32'd0});
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in cycle 20 clears results asynchronously.
        u   = 1'b1;
        x   = 32'd12345;
        y   = 32'd5;
        run = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("midreset_quot", quot, 32'd0);
        check_output("midreset_rem", rem, 32'd0);
        run = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 32'd12345, 32'd5, {32'd2469, 32'd0});

        // Random back-to-back regression against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic        ru;
            logic [31:0] rx;
            logic [31:0] ry;
            int          sel;
            ru  = 1'($urandom_range(0, 1));
            rx  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 20));
                2:       ry = 32'hFFFFFFFF;
                3:       ry = 32'd0 - 32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            apply_stimulus(ru, rx, ry, ref_div(ru, rx, ry));
        end
        run = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL pending_results: got %0d unmatched, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
